// File: rtl/leap_pkg.sv
// Shared Leap link definitions: state codes and default frame geometry,
// common to the transmitter and the receiver.
package leap_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_START = 4'd1,
    ST_DATA  = 4'd2,
    ST_STOP  = 4'd3,
    ST_GAP   = 4'd4
  } leap_state_t;

  localparam int LEAP_CLKS_PER_BIT = 434;
  localparam int LEAP_NUM_BYTES    = 5;
  localparam int LEAP_FRAME_W      = 8 * LEAP_NUM_BYTES;

endpackage

// File: rtl/leap_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each period with tick. restart holds the count at zero.
module leap_bit_timer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst || restart || tick) cnt <= '0;
    else                        cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/leap_out.sv
// Leap link transmitter: sends a latched NUM_BYTES word as 8N1 characters,
// byte 0 first, LSB first. Define LEAP_OUT_GAP_EN for inter-character gaps.
module leap_out
  import leap_pkg::*;
#(
  parameter int CLKS_PER_BIT = LEAP_CLKS_PER_BIT,
  parameter int NUM_BYTES    = LEAP_NUM_BYTES,
  parameter int GAP_BITS     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [8*NUM_BYTES-1:0] in_bytes,
  output logic                   serial,
  output logic                   busy,
  output logic                   done,
  output logic [3:0]             state
);

  localparam int BW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  if (CLKS_PER_BIT < 2 || NUM_BYTES < 1 || GAP_BITS < 1) begin : g_bad_param
    $error("leap_out: illegal parameter value");
  end

  leap_state_t                 st;
  logic [NUM_BYTES-1:0][7:0]   frame;
  logic [BW-1:0]               byte_idx;
  logic [2:0]                  bit_idx;
  logic [7:0]                  shreg;
  logic [7:0]                  cur_byte;
  logic                        tick;

`ifdef LEAP_OUT_GAP_EN
  localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  logic [GW-1:0] gap_cnt;
`endif

  assign cur_byte = frame[byte_idx];
  assign state    = st;

  // Timer is parked at zero while idle so the start bit gets a full period.
  leap_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (st == ST_IDLE),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= ST_IDLE;
      serial   <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      frame    <= '0;
      byte_idx <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
`ifdef LEAP_OUT_GAP_EN
      gap_cnt  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (st)
        ST_IDLE: begin
          serial <= 1'b1;
          if (start) begin
            frame    <= in_bytes;
            byte_idx <= '0;
            bit_idx  <= '0;
            st       <= ST_START;
            serial   <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_START: if (tick) begin
          st      <= ST_DATA;
          bit_idx <= '0;
          shreg   <= cur_byte;
          serial  <= cur_byte[0];
        end
        // serial always mirrors shreg[0]; the next bit is shreg[1] before the shift.
        ST_DATA: if (tick) begin
          if (bit_idx == 3'd7) begin
            st     <= ST_STOP;
            serial <= 1'b1;
          end else begin
            bit_idx <= bit_idx + 3'd1;
            shreg   <= shreg >> 1;
            serial  <= shreg[1];
          end
        end
        ST_STOP: if (tick) begin
          if (byte_idx < BW'(NUM_BYTES - 1)) begin
            byte_idx <= byte_idx + BW'(1);
`ifdef LEAP_OUT_GAP_EN
            st      <= ST_GAP;
            gap_cnt <= '0;
`else
            st      <= ST_START;
            serial  <= 1'b0;
`endif
          end else begin
            st   <= ST_IDLE;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
`ifdef LEAP_OUT_GAP_EN
        ST_GAP: if (tick) begin
          if (gap_cnt == GW'(GAP_BITS - 1)) begin
            st      <= ST_START;
            serial  <= 1'b0;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
`endif
        default: begin
          st     <= ST_IDLE;
          serial <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_leap_out.sv
// Randomized scoreboard bench for leap_out: stimulus queues expected words,
// a line monitor decodes the serial waveform as a UART receiver and compares.
`timescale 1ns/1ps
module tb_leap_out;

  localparam int C  = 16;
  localparam int NB = 5;
  localparam int GB = 2;
`ifdef LEAP_OUT_GAP_EN
  localparam int G       = GB * C;
  localparam bit EXP_GAP = 1'b1;
`else
  localparam int G       = 0;
  localparam bit EXP_GAP = 1'b0;
`endif
  localparam int CH = 10 * C + G;
  localparam int L  = NB * 10 * C + (NB - 1) * G;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [8*NB-1:0] in_bytes = '0;
  logic            serial, busy, done;
  logic [3:0]      state;

  leap_out #(.CLKS_PER_BIT(C), .NUM_BYTES(NB), .GAP_BITS(GB)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_bytes (in_bytes),
    .serial   (serial),
    .busy     (busy),
    .done     (done),
    .state    (state)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [8*NB-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- line monitor / scoreboard ----------------
  logic line_buf[L];
  int   idx = 0;
  bit   rec = 1'b0;
  bit   busy_ok, saw_gap;

  task automatic finish_frame();
    logic [8*NB-1:0] exp_w;
    logic [7:0]      got;
    logic            lvl;
    bit              frame_ok;
    int              base;
    check("frame_len", 64'(idx), 64'(L));
    check("busy_in_frame", 64'(busy_ok), 64'(1));
    check("busy_at_done", 64'(busy), 64'(0));
    check("gap_state_seen", 64'(saw_gap), 64'(EXP_GAP));
    if (exp_q.size() == 0) begin
      check("unexpected_frame", 64'(1), 64'(0));
    end else begin
      exp_w = exp_q.pop_front();
      for (int b = 0; b < NB; b++) begin
        base     = b * CH;
        frame_ok = 1'b1;
        got      = '0;
        for (int i = 0; i < 10; i++) begin
          lvl = line_buf[base + i*C];
          for (int j = 0; j < C; j++)
            if (line_buf[base + i*C + j] !== lvl) frame_ok = 1'b0;
          if (i == 0 && lvl !== 1'b0) frame_ok = 1'b0;
          if (i == 9 && lvl !== 1'b1) frame_ok = 1'b0;
          if (i >= 1 && i <= 8) got[i-1] = lvl;
        end
        if (b < NB - 1)
          for (int j = 0; j < G; j++)
            if (line_buf[base + 10*C + j] !== 1'b1) frame_ok = 1'b0;
        check($sformatf("byte%0d", b), 64'(got), 64'(exp_w[b*8 +: 8]));
        check($sformatf("framing%0d", b), 64'(frame_ok), 64'(1));
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      rec = 1'b0;
    end else if (rec) begin
      if (done) begin
        finish_frame();
        rec = 1'b0;
      end else if (idx >= L) begin
        check("done_at_frame_end", 64'(0), 64'(1));
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        rec = 1'b0;
      end else begin
        line_buf[idx] = serial;
        idx++;
        if (!busy) busy_ok = 1'b0;
        if (state == 4'd4) saw_gap = 1'b1;
      end
    end else begin
      if (done) check("spurious_done", 64'(1), 64'(0));
      if (serial == 1'b0) begin
        rec         = 1'b1;
        line_buf[0] = 1'b0;
        idx         = 1;
        busy_ok     = busy;
        saw_gap     = (state == 4'd4);
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [8*NB-1:0] rnd_frame();
    return (8*NB)'({$urandom(), $urandom()});
  endfunction

  // Called at posedge+1 with the DUT idle (or in its done cycle).
  task automatic send(input logic [8*NB-1:0] d);
    in_bytes = d;
    start    = 1'b1;
    exp_q.push_back(d);
    @(posedge clk); #1;
    start = 1'b0;
    check("lat_serial", 64'(serial), 64'(0));
    check("lat_state", 64'(state), 64'(1));
    check("lat_busy", 64'(busy), 64'(1));
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < L + 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_timeout", 64'(done), 64'(1));
  endtask

  initial begin
    bit s_ok, b_ok, d_ok, st_ok;
    int off;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_serial", 64'(serial), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_state", 64'(state), 64'(0));

    s_ok = 1; b_ok = 1; d_ok = 1; st_ok = 1;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (serial !== 1'b1) s_ok = 0;
      if (busy !== 1'b0) b_ok = 0;
      if (done !== 1'b0) d_ok = 0;
      if (state !== 4'd0) st_ok = 0;
    end
    check("idle_serial", 64'(s_ok), 64'(1));
    check("idle_busy", 64'(b_ok), 64'(1));
    check("idle_done", 64'(d_ok), 64'(1));
    check("idle_state", 64'(st_ok), 64'(1));

    // Directed pattern, then loopback word sent back-to-back in the done cycle.
    send(40'h55_A5_0F_F0_01);
    wait_done();
    send(40'hDE_AD_BE_EF_42);
    wait_done();

    // start pulses and in_bytes changes mid-frame must be ignored.
    @(posedge clk); #1;
    send(rnd_frame());
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(20, 100)) @(posedge clk);
      #1;
      start    = 1'b1;
      in_bytes = rnd_frame();
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_done();
    repeat (3 * C) @(posedge clk);
    #1;
    check("no_extra_frame", 64'(busy), 64'(0));

    // Reset during byte 2, data bit 4.
    send(rnd_frame());
    off = 2 * CH + 5 * C + C / 2;
    repeat (off) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(exp_q.pop_back());
    check("midrst_serial", 64'(serial), 64'(1));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_state", 64'(state), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    send(rnd_frame());
    wait_done();

    // Random frames, mixing back-to-back and idle-separated starts.
    for (int f = 0; f < 15; f++) begin
      if ($urandom_range(0, 1) == 0) begin
        repeat ($urandom_range(1, 20)) @(posedge clk);
        #1;
      end
      send(rnd_frame());
      wait_done();
    end

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
